// File: rtl/uart_engine_fc.sv
// UART engine with TX/RX byte FIFOs, valid/ready streams, RTS/CTS flow control,
// loopback, flush, RX idle timeout, overrun detection and a maskable interrupt.
module uart_engine_fc #(
   parameter int FIFO_DEPTH   = 1024,
   parameter int CNT_W        = 16,
   parameter int TIMEOUT_BITS = 40,
   localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      clk_div,
   input  logic             check_en,
   input  logic [1:0]       check_type,
   input  logic [1:0]       data_bit,
   input  logic [1:0]       stop_bit,
   input  logic             tx_en,
   input  logic             loopback,
   input  logic             flow_en,
   input  logic             tx_flush,
   input  logic             rx_flush,
   input  logic [CW-1:0]    rts_level,
   input  logic [CW-1:0]    rx_irq_level,
   input  logic [4:0]       irq_mask,
   input  logic [4:0]       irq_clr,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             uart_tx,
   input  logic             uart_rx,
   input  logic             cts_n,
   output logic             rts_n,
   output logic [CW-1:0]    tx_count,
   output logic [CW-1:0]    rx_count,
   output logic             tx_busy,
   output logic             rx_busy,
   output logic [4:0]       irq_status,
   output logic             irq,
   output logic [CNT_W-1:0] tx_byte_count,
   output logic [CNT_W-1:0] rx_byte_count,
   output logic [CNT_W-1:0] overrun_count
);

   localparam int AW = CW - 1;
   localparam int TW = $clog2(TIMEOUT_BITS + 1);
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {T_IDLE, T_WAIT_CTS, T_SEND} tx_st_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_BITS} rx_st_t;

   function automatic logic par_of(input logic [7:0] d, input logic [1:0] t);
      unique case (t)
         2'd0:    par_of = ^d;
         2'd1:    par_of = ~^d;
         2'd2:    par_of = 1'b1;
         default: par_of = 1'b0;
      endcase
   endfunction

   logic [31:0] div_eff;
   logic [3:0]  ndat;
   logic [7:0]  dmask;

   assign div_eff = (clk_div == 32'd0) ? 32'd1 : clk_div;
   assign ndat    = 4'd5 + {2'b00, data_bit};
   assign dmask   = 8'hFF >> (2'd3 - data_bit);

   logic       init_q;
   logic [1:0] cts_sq;
   logic [1:0] rx_sq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q <= 1'b0;
         cts_sq <= 2'b11;
         rx_sq  <= 2'b11;
      end else begin
         init_q <= 1'b1;
         cts_sq <= {cts_sq[0], cts_n};
         rx_sq  <= {rx_sq[0], uart_rx};
      end
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wp, tx_rp;
   logic          tx_push, tx_load;

   assign tx_ready = init_q && (tx_count != DEPTH) && !tx_flush;
   assign tx_push  = tx_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= tx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_count <= '0;
      end else if (tx_flush) begin
         tx_rp    <= tx_wp;
         tx_count <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_load) tx_rp <= tx_rp + 1'b1;
         tx_count <= tx_count + CW'(tx_push) - CW'(tx_load);
      end
   end

   // ---------------- TX launch FSM ----------------
   tx_st_t tx_st, tx_st_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_st <= T_IDLE;
      else        tx_st <= tx_st_nx;
   end

   // CTS is only consulted once the core is idle, so it gates frame starts only.
   always_comb begin
      tx_st_nx = tx_st;
      tx_load  = 1'b0;
      unique case (tx_st)
         T_IDLE:
            if (tx_en && tx_count != '0 && !tx_busy) tx_st_nx = T_WAIT_CTS;
         T_WAIT_CTS:
            if (!tx_en || tx_count == '0 || tx_flush) tx_st_nx = T_IDLE;
            else if (!flow_en || !cts_sq[1])          tx_st_nx = T_SEND;
         T_SEND: begin
            tx_st_nx = T_IDLE;
            tx_load  = (tx_count != '0) && !tx_flush && !tx_busy;
         end
         default: tx_st_nx = T_IDLE;
      endcase
   end

   // ---------------- TX core ----------------
   logic [7:0]  tx_byte;
   logic [11:0] tx_frame, tx_sh;
   logic [3:0]  tx_nb, tx_left;
   logic [31:0] tx_tmr;
   logic        tx_line;

   assign tx_byte = tx_mem[tx_rp] & dmask;
   assign tx_line = tx_sh[0];
   assign uart_tx = loopback ? 1'b1 : tx_line;

   always_comb begin
      tx_frame    = '1;
      tx_frame[0] = 1'b0;
      for (int i = 0; i < 8; i++)
         if (i < int'(ndat)) tx_frame[i+1] = tx_byte[i];
      if (check_en) tx_frame[ndat + 4'd1] = par_of(tx_byte, check_type);
      tx_nb = ndat + 4'd1 + {3'b000, check_en}
            + ((stop_bit == 2'd0) ? 4'd1 : 4'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sh   <= '1;
         tx_left <= '0;
         tx_tmr  <= '0;
         tx_busy <= 1'b0;
      end else if (tx_load) begin
         tx_sh   <= tx_frame;
         tx_left <= tx_nb;
         tx_tmr  <= '0;
         tx_busy <= 1'b1;
      end else if (tx_busy) begin
         if (tx_tmr >= div_eff - 32'd1) begin
            tx_tmr  <= '0;
            tx_sh   <= {1'b1, tx_sh[11:1]};
            tx_left <= tx_left - 4'd1;
            if (tx_left <= 4'd1) tx_busy <= 1'b0;
         end else begin
            tx_tmr <= tx_tmr + 32'd1;
         end
      end
   end

   // ---------------- RX core ----------------
   rx_st_t      rx_st, rx_st_nx;
   logic [31:0] rx_tmr;
   logic [3:0]  rx_idx, rx_tot;
   logic [15:0] rx_sh, rx_fr;
   logic [7:0]  rx_word;
   logic        rx_in, rx_tick, rx_done, rx_bad;

   assign rx_in   = loopback ? tx_line : rx_sq[1];
   assign rx_tot  = ndat + {3'b000, check_en} + 4'd1;
   assign rx_busy = (rx_st != R_IDLE);
   assign rx_tick = (rx_st == R_START) ? (rx_tmr >= (div_eff >> 1))
                                       : (rx_tmr >= div_eff - 32'd1);

   always_comb begin
      rx_fr         = rx_sh;
      rx_fr[rx_idx] = rx_in;
      rx_word       = rx_fr[7:0] & dmask;
      rx_bad        = !rx_fr[ndat + {3'b000, check_en}]
                    || (check_en && rx_fr[ndat] != par_of(rx_word, check_type));
   end

   always_comb begin
      rx_st_nx = rx_st;
      rx_done  = 1'b0;
      unique case (rx_st)
         R_IDLE:
            if (!rx_in) rx_st_nx = R_START;
         R_START:
            if (rx_tick) rx_st_nx = rx_in ? R_IDLE : R_BITS;
         R_BITS:
            if (rx_tick && rx_idx >= rx_tot - 4'd1) begin
               rx_st_nx = R_IDLE;
               rx_done  = 1'b1;
            end
         default: rx_st_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st  <= R_IDLE;
         rx_tmr <= '0;
         rx_idx <= '0;
         rx_sh  <= '0;
      end else begin
         rx_st <= rx_st_nx;
         if (rx_st == R_IDLE) begin
            rx_tmr <= '0;
            rx_idx <= '0;
         end else if (rx_tick) begin
            rx_tmr <= '0;
            if (rx_st == R_BITS) begin
               rx_sh  <= rx_fr;
               rx_idx <= rx_idx + 4'd1;
            end
         end else begin
            rx_tmr <= rx_tmr + 32'd1;
         end
      end
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] rx_wp, rx_rp;
   logic          rx_full, rx_wr, rx_pop;

   assign rx_full  = (rx_count == DEPTH);
   assign rx_wr    = rx_done && !rx_full;
   assign rx_valid = (rx_count != '0);
   assign rx_pop   = rx_valid && rx_ready && !rx_flush;
   assign rx_data  = rx_valid ? rx_mem[rx_rp] : 8'h00;

   always_ff @(posedge clk) begin
      if (rx_wr) rx_mem[rx_wp] <= rx_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wp    <= '0;
         rx_rp    <= '0;
         rx_count <= '0;
      end else begin
         if (rx_wr) rx_wp <= rx_wp + 1'b1;
         if (rx_flush) begin
            rx_rp    <= rx_wp;
            rx_count <= CW'(rx_wr);
         end else begin
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_count <= rx_count + CW'(rx_wr) - CW'(rx_pop);
         end
      end
   end

   // ---------------- counters, RTS, timeout ----------------
   logic [31:0]   tm_div;
   logic [TW-1:0] tm_cnt;
   logic          tm_clr, tm_tick, tmo_set;

   assign tm_clr  = rx_done || rx_pop || rx_flush || (rx_count == '0);
   assign tm_tick = !tm_clr && !rx_busy && (tm_div >= div_eff - 32'd1);
   assign tmo_set = tm_tick && (tm_cnt == TW'(TIMEOUT_BITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_byte_count <= '0;
         rx_byte_count <= '0;
         overrun_count <= '0;
         rts_n         <= 1'b1;
         tm_div        <= '0;
         tm_cnt        <= '0;
      end else begin
         if (tx_load)            tx_byte_count <= tx_byte_count + 1'b1;
         if (rx_wr)              rx_byte_count <= rx_byte_count + 1'b1;
         if (rx_done && rx_full) overrun_count <= overrun_count + 1'b1;
         rts_n <= flow_en && (rx_count >= rts_level);
         if (tm_clr) begin
            tm_div <= '0;
            tm_cnt <= '0;
         end else if (!rx_busy) begin
            if (tm_tick) begin
               tm_div <= '0;
               if (tm_cnt != TW'(TIMEOUT_BITS)) tm_cnt <= tm_cnt + 1'b1;
            end else begin
               tm_div <= tm_div + 32'd1;
            end
         end
      end
   end

   // ---------------- interrupt ----------------
   logic [4:0] st_nx;

   always_comb begin
      st_nx[0] = (tx_count == '0) && !tx_busy;
      st_nx[1] = (rx_irq_level != '0) && (rx_count >= rx_irq_level);
      st_nx[2] = tmo_set || (irq_status[2] && !irq_clr[2]);
      st_nx[3] = (rx_done && rx_full) || (irq_status[3] && !irq_clr[3]);
      st_nx[4] = (rx_done && rx_bad) || (irq_status[4] && !irq_clr[4]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_status <= '0;
         irq        <= 1'b0;
      end else begin
         irq_status <= st_nx;
         irq        <= |(st_nx & irq_mask);
      end
   end

endmodule

// File: tb/tb_uart_engine_fc.sv
// Directed bench for uart_engine_fc: loopback, CTS gating, RTS/overrun,
// idle timeout, parity error interrupt, TX flush and async reset.
module tb_uart_engine_fc;

   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   clk_div;
   logic          check_en;
   logic [1:0]    check_type, data_bit, stop_bit;
   logic          tx_en, loopback, flow_en, tx_flush, rx_flush;
   logic [CW-1:0] rts_level, rx_irq_level;
   logic [4:0]    irq_mask, irq_clr;
   logic [7:0]    tx_data;
   logic          tx_valid, tx_ready;
   logic [7:0]    rx_data;
   logic          rx_valid, rx_ready;
   logic          uart_tx, uart_rx, cts_n, rts_n;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_busy, rx_busy;
   logic [4:0]    irq_status;
   logic          irq;
   logic [15:0]   tx_byte_count, rx_byte_count, overrun_count;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int low_cnt = 0;
   int base_low, k;

   uart_engine_fc #(
      .FIFO_DEPTH(4), .CNT_W(16), .TIMEOUT_BITS(40)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
      .check_en(check_en), .check_type(check_type),
      .data_bit(data_bit), .stop_bit(stop_bit),
      .tx_en(tx_en), .loopback(loopback), .flow_en(flow_en),
      .tx_flush(tx_flush), .rx_flush(rx_flush),
      .rts_level(rts_level), .rx_irq_level(rx_irq_level),
      .irq_mask(irq_mask), .irq_clr(irq_clr),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .uart_tx(uart_tx), .uart_rx(uart_rx),
      .cts_n(cts_n), .rts_n(rts_n),
      .tx_count(tx_count), .rx_count(rx_count),
      .tx_busy(tx_busy), .rx_busy(rx_busy),
      .irq_status(irq_status), .irq(irq),
      .tx_byte_count(tx_byte_count), .rx_byte_count(rx_byte_count),
      .overrun_count(overrun_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (uart_tx == 1'b0) low_cnt <= low_cnt + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   task automatic pop();
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   task automatic clr(input logic [4:0] m);
      irq_clr = m;
      tick(1);
      irq_clr = 5'h00;
   endtask

   task automatic send_byte(input logic [7:0] d, input int div,
                            input logic pen, input logic pbit);
      uart_rx = 1'b0;
      tick(div);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         tick(div);
      end
      if (pen) begin
         uart_rx = pbit;
         tick(div);
      end
      uart_rx = 1'b1;
      tick(div);
   endtask

   initial begin
      rst_n = 1'b0;
      clk_div = 32'd16; check_en = 1'b0; check_type = 2'd0;
      data_bit = 2'd3; stop_bit = 2'd0;
      tx_en = 1'b0; loopback = 1'b0; flow_en = 1'b0;
      tx_flush = 1'b0; rx_flush = 1'b0;
      rts_level = 3'd3; rx_irq_level = 3'd0;
      irq_mask = 5'h00; irq_clr = 5'h00;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
      uart_rx = 1'b1; cts_n = 1'b1;
      tick(3);

      chk("rst_uart_tx", 32'(uart_tx), 1);
      chk("rst_rts_n", 32'(rts_n), 1);
      chk("rst_tx_ready", 32'(tx_ready), 0);
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_rx_data", 32'(rx_data), 0);
      chk("rst_counts", 32'({tx_count, rx_count}), 0);
      chk("rst_irq", 32'({irq_status, irq}), 0);
      chk("rst_bytecnt", 32'({tx_byte_count, rx_byte_count}), 0);
      rst_n = 1'b1;
      chk("rel_tx_ready0", 32'(tx_ready), 0);
      tick(1);
      chk("rel_tx_ready1", 32'(tx_ready), 1);
      chk("rel_rts_n", 32'(rts_n), 0);
      tick(1);
      chk("tx_empty_lvl", 32'(irq_status), 'h01);

      // loopback: two bytes round trip, pin stays idle
      loopback = 1'b1;
      base_low = low_cnt;
      push(8'h55);
      push(8'hA3);
      chk("lb_tx_count", 32'(tx_count), 2);
      tx_en = 1'b1;
      k = 0;
      while (rx_count != 3'd2 && k < 800) begin tick(1); k++; end
      chk("lb_rx_count", 32'(rx_count), 2);
      chk("lb_rx_bytes", 32'(rx_byte_count), 2);
      chk("lb_tx_bytes", 32'(tx_byte_count), 2);
      chk("lb_data0", 32'(rx_data), 'h55);
      pop();
      chk("lb_data1", 32'(rx_data), 'hA3);
      pop();
      chk("lb_empty", 32'(rx_valid), 0);
      chk("lb_pin_idle", 32'(low_cnt - base_low), 0);
      tx_en = 1'b0;
      loopback = 1'b0;
      tick(5);

      // CTS gating between frames
      flow_en = 1'b1;
      cts_n = 1'b1;
      tick(2);
      chk("fc_rts_low", 32'(rts_n), 0);
      push(8'h01); push(8'h02); push(8'h03);
      tx_en = 1'b1;
      base_low = low_cnt;
      tick(400);
      chk("fc_held_bytes", 32'(tx_byte_count), 2);
      chk("fc_held_pin", 32'(low_cnt - base_low), 0);
      chk("fc_held_count", 32'(tx_count), 3);
      cts_n = 1'b0;
      k = 0;
      while (tx_byte_count != 16'd4 && k < 600) begin tick(1); k++; end
      chk("fc_frame2_start", 32'(tx_byte_count), 4);
      cts_n = 1'b1;
      k = 0;
      while (tx_busy && k < 400) begin tick(1); k++; end
      tick(50);
      chk("fc_frame3_held", 32'(tx_byte_count), 4);
      chk("fc_one_left", 32'(tx_count), 1);
      chk("fc_line_idle", 32'({uart_tx, tx_busy}), 'b10);
      cts_n = 1'b0;
      k = 0;
      while ((tx_count != 3'd0 || tx_busy) && k < 600) begin tick(1); k++; end
      chk("fc_all_sent", 32'(tx_byte_count), 5);
      tx_en = 1'b0;

      // RTS and overrun with external RX traffic
      rx_irq_level = 3'd2;
      clr(5'h1f);
      send_byte(8'h11, 16, 1'b0, 1'b0);
      send_byte(8'h22, 16, 1'b0, 1'b0);
      tick(2);
      chk("ov_rts_lo", 32'(rts_n), 0);
      chk("ov_thresh", 32'(irq_status[1]), 1);
      send_byte(8'h33, 16, 1'b0, 1'b0);
      tick(2);
      chk("ov_rts_hi", 32'(rts_n), 1);
      send_byte(8'h44, 16, 1'b0, 1'b0);
      send_byte(8'h55, 16, 1'b0, 1'b0);
      tick(2);
      chk("ov_rx_count", 32'(rx_count), 4);
      chk("ov_overruns", 32'(overrun_count), 1);
      chk("ov_flag", 32'(irq_status[3]), 1);
      chk("ov_rx_bytes", 32'(rx_byte_count), 6);
      chk("ov_d0", 32'(rx_data), 'h11); pop();
      chk("ov_d1", 32'(rx_data), 'h22); pop();
      chk("ov_d2", 32'(rx_data), 'h33); pop();
      chk("ov_d3", 32'(rx_data), 'h44); pop();
      chk("ov_drained", 32'(rx_valid), 0);
      rx_irq_level = 3'd0;
      flow_en = 1'b0;

      // RX flush
      send_byte(8'h66, 16, 1'b0, 1'b0);
      tick(2);
      chk("rf_before", 32'(rx_count), 1);
      rx_flush = 1'b1;
      tick(1);
      rx_flush = 1'b0;
      chk("rf_after", 32'({rx_valid, rx_count}), 0);

      // idle timeout
      clk_div = 32'd8;
      clr(5'h1f);
      send_byte(8'h5A, 8, 1'b0, 1'b0);
      tick(290);
      chk("tmo_early", 32'(irq_status[2]), 0);
      k = 0;
      while (!irq_status[2] && k < 80) begin tick(1); k++; end
      chk("tmo_set", 32'(irq_status[2]), 1);
      clr(5'h04);
      chk("tmo_clr", 32'(irq_status[2]), 0);
      chk("tmo_data", 32'(rx_data), 'h5A);
      pop();
      send_byte(8'hC3, 8, 1'b0, 1'b0);
      tick(100);
      chk("tmo_data2", 32'(rx_data), 'hC3);
      pop();
      tick(400);
      chk("tmo_none", 32'(irq_status[2]), 0);

      // parity error interrupt, even parity
      check_en = 1'b1;
      check_type = 2'd0;
      irq_mask = 5'h10;
      clr(5'h1f);
      send_byte(8'h0F, 8, 1'b1, 1'b0);
      tick(3);
      chk("par_ok_err", 32'({irq_status[4], irq}), 0);
      chk("par_ok_data", 32'(rx_data), 'h0F);
      pop();
      send_byte(8'h07, 8, 1'b1, 1'b0);
      tick(3);
      chk("par_bad_err", 32'({irq_status[4], irq}), 'b11);
      clr(5'h10);
      chk("par_clr", 32'({irq_status[4], irq}), 0);
      rx_flush = 1'b1;
      tick(1);
      rx_flush = 1'b0;
      check_en = 1'b0;
      irq_mask = 5'h00;

      // TX flush mid burst
      clk_div = 32'd16;
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      chk("fl_full", 32'({tx_count, tx_ready}), {3'd4, 1'b0});
      tx_en = 1'b1;
      k = 0;
      while (!tx_busy && k < 20) begin tick(1); k++; end
      tick(40);
      chk("fl_queued", 32'(tx_count), 3);
      tx_flush = 1'b1;
      tx_data = 8'hEE;
      tx_valid = 1'b1;
      #1;
      chk("fl_ready_lo", 32'(tx_ready), 0);
      tick(1);
      tx_flush = 1'b0;
      tx_valid = 1'b0;
      chk("fl_emptied", 32'({tx_count, tx_busy}), {3'd0, 1'b1});
      k = 0;
      while (tx_busy && k < 300) begin tick(1); k++; end
      tick(2);
      chk("fl_tx_empty", 32'(irq_status[0]), 1);
      tick(300);
      chk("fl_no_more", 32'(tx_byte_count), 6);

      // async reset mid-frame
      push(8'h00);
      k = 0;
      while (uart_tx && k < 20) begin tick(1); k++; end
      chk("rs_started", 32'(uart_tx), 0);
      tick(20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs_line", 32'(uart_tx), 1);
      chk("rs_state", 32'({tx_busy, tx_count, tx_ready}), 0);
      chk("rs_cnt", 32'(tx_byte_count), 0);
      tick(2);
      rst_n = 1'b1;
      tick(50);
      chk("rs_quiet", 32'({uart_tx, tx_busy}), 'b10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
